// File: rtl/alu_operand_stage_pkg.sv
// Shared types and helpers for the ALU operand-select stage.
// Holds the input2 source encoding, the stage state encoding and sign extension.
package alu_operand_pkg;

  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_IMM  = 2'd1,
    SRC_ADDR = 2'd2,
    SRC_BR   = 2'd3
  } src_sel_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int unsigned SEXT_W = 64;

  // Sign-extends the low w bits of val to SEXT_W bits by replicating bit w-1.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] val,
                                             input int unsigned w);
    logic signed [SEXT_W-1:0] t;
    t = $signed(val << (SEXT_W - w));
    return t >>> (SEXT_W - w);
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side operand bus, forwarding bus and ALU-side output handshake.
// The master drives decode/forwarding/out_ready; the slave is the operand stage.
interface alu_operand_stage_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int IMM_W   = 20,
  parameter int ADDR_W  = 15,
  parameter int BR_W    = 25,
  parameter int NUM_FWD = 2
) ();
  import alu_operand_pkg::*;

  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  src_sel_e                    src_sel;
  logic [REG_AW-1:0]           rs1_idx;
  logic [REG_AW-1:0]           rs2_idx;
  logic [DATA_W-1:0]           read_data1;
  logic [DATA_W-1:0]           read_data2;
  logic [IMM_W-1:0]            immediate;
  logic [ADDR_W-1:0]           imm_addr;
  logic [BR_W-1:0]             branch_off;
  logic [NUM_FWD-1:0]          fwd_valid;
  logic [NUM_FWD-1:0]          fwd_pend;
  logic [NUM_FWD*REG_AW-1:0]   fwd_idx;
  logic [NUM_FWD*DATA_W-1:0]   fwd_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_W-1:0]           input1;
  logic [DATA_W-1:0]           input2;
  logic [15:0]                 stall_cnt;

  modport master (
    output flush, in_valid, src_sel, rs1_idx, rs2_idx, read_data1, read_data2,
           immediate, imm_addr, branch_off, fwd_valid, fwd_pend, fwd_idx,
           fwd_data, out_ready,
    input  in_ready, out_valid, input1, input2, stall_cnt
  );

  modport slave (
    input  flush, in_valid, src_sel, rs1_idx, rs2_idx, read_data1, read_data2,
           immediate, imm_addr, branch_off, fwd_valid, fwd_pend, fwd_idx,
           fwd_data, out_ready,
    output in_ready, out_valid, input1, input2, stall_cnt
  );

endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// Forwarding mux for one source operand: picks the newest valid in-flight
// result whose destination matches the index, else the register-file data.
module operand_fwd_mux #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_AW-1:0]         i_idx,
  input  logic [DATA_W-1:0]         i_reg_data,
  input  logic [NUM_FWD-1:0]        i_fwd_valid,
  input  logic [NUM_FWD-1:0]        i_fwd_pend,
  input  logic [NUM_FWD*REG_AW-1:0] i_fwd_idx,
  input  logic [NUM_FWD*DATA_W-1:0] i_fwd_data,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_hit,
  output logic                      o_pend
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_data = i_reg_data;
    o_hit  = 1'b0;
    o_pend = 1'b0;
    // Walk from oldest to newest so the lowest-index match is the last writer.
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (i_fwd_valid[k] && (i_fwd_idx[k*REG_AW +: REG_AW] == i_idx) &&
          (i_idx != '0)) begin
        o_data = i_fwd_data[k*DATA_W +: DATA_W];
        o_hit  = 1'b1;
        o_pend = i_fwd_pend[k];
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand-select stage: forwards rs1/rs2, forms input2 from the
// selected source, waits out load-use hazards and presents a valid/ready output.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int IMM_W   = 20,
  parameter int ADDR_W  = 15,
  parameter int BR_W    = 25,
  parameter int NUM_FWD = 2
) (
  input logic               clk,
  input logic               rst,
  alu_operand_stage_if.slave bus
);

  state_e            r_state;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [REG_AW-1:0] r_rs1_idx;
  logic [REG_AW-1:0] r_rs2_idx;
  logic              r_wait1;
  logic              r_wait2;
  logic [DATA_W-1:0] r_input1;
  logic [DATA_W-1:0] r_input2;
  logic [15:0]       r_stall_cnt;

  logic              w_in_wait;
  logic              w_in_ready;
  logic              w_accept;
  logic [REG_AW-1:0] w_idx1;
  logic [REG_AW-1:0] w_idx2;
  logic [DATA_W-1:0] w_reg1;
  logic [DATA_W-1:0] w_reg2;
  logic [DATA_W-1:0] w_data1;
  logic [DATA_W-1:0] w_data2;
  logic              w_hit1;
  logic              w_hit2;
  logic              w_pend1;
  logic              w_pend2;

  // While waiting, the muxes re-resolve the captured indices against the live
  // forward bus, with the captured raw values standing in for register data.
  assign w_in_wait = (r_state == WAIT);
  assign w_idx1    = w_in_wait ? r_rs1_idx : bus.rs1_idx;
  assign w_idx2    = w_in_wait ? r_rs2_idx : bus.rs2_idx;
  assign w_reg1    = w_in_wait ? r_op1     : bus.read_data1;
  assign w_reg2    = w_in_wait ? r_op2     : bus.read_data2;

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .i_idx      (w_idx1),
    .i_reg_data (w_reg1),
    .i_fwd_valid(bus.fwd_valid),
    .i_fwd_pend (bus.fwd_pend),
    .i_fwd_idx  (bus.fwd_idx),
    .i_fwd_data (bus.fwd_data),
    .o_data     (w_data1),
    .o_hit      (w_hit1),
    .o_pend     (w_pend1)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .i_idx      (w_idx2),
    .i_reg_data (w_reg2),
    .i_fwd_valid(bus.fwd_valid),
    .i_fwd_pend (bus.fwd_pend),
    .i_fwd_idx  (bus.fwd_idx),
    .i_fwd_data (bus.fwd_data),
    .o_data     (w_data2),
    .o_hit      (w_hit2),
    .o_pend     (w_pend2)
  );

  logic [SEXT_W-1:0] w_imm_ext;
  logic [SEXT_W-1:0] w_addr_ext;
  logic [SEXT_W-1:0] w_br_ext;
  logic [DATA_W-1:0] w_op2_new;
  logic              w_stall1;
  logic              w_stall2;

  assign w_imm_ext  = sext(SEXT_W'(bus.immediate),  IMM_W);
  assign w_addr_ext = sext(SEXT_W'(bus.imm_addr),   ADDR_W);
  assign w_br_ext   = sext(SEXT_W'(bus.branch_off), BR_W);

  always_comb begin
    w_op2_new = w_data2;
    case (bus.src_sel)
      SRC_REG:  w_op2_new = w_data2;
      SRC_IMM:  w_op2_new = w_imm_ext[DATA_W-1:0];
      SRC_ADDR: w_op2_new = w_addr_ext[DATA_W-1:0];
      SRC_BR:   w_op2_new = w_br_ext[DATA_W-1:0];
      default:  w_op2_new = w_data2;
    endcase
  end

  // rs2 only matters (and can only stall) when input2 comes from the register.
  assign w_stall1   = w_hit1 & w_pend1;
  assign w_stall2   = (bus.src_sel == SRC_REG) & w_hit2 & w_pend2;
  assign w_in_ready = (r_state == EMPTY) | ((r_state == FULL) & bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

  logic              w_wait1_next;
  logic              w_wait2_next;
  logic [DATA_W-1:0] w_op1_res;
  logic [DATA_W-1:0] w_op2_res;

  // A flag clears on a non-pending match (take its data) or on no match
  // (producer retired: w_data falls back to the captured value).
  assign w_wait1_next = r_wait1 & w_hit1 & w_pend1;
  assign w_wait2_next = r_wait2 & w_hit2 & w_pend2;
  assign w_op1_res    = (r_wait1 & ~w_wait1_next) ? w_data1 : r_op1;
  assign w_op2_res    = (r_wait2 & ~w_wait2_next) ? w_data2 : r_op2;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; the operand
    // and output registers are reset too because input1/input2 must read 0.
    if (rst) begin
      r_state     <= EMPTY;
      r_op1       <= '0;
      r_op2       <= '0;
      r_rs1_idx   <= '0;
      r_rs2_idx   <= '0;
      r_wait1     <= 1'b0;
      r_wait2     <= 1'b0;
      r_input1    <= '0;
      r_input2    <= '0;
      r_stall_cnt <= '0;
    end else if (bus.flush) begin
      r_state <= EMPTY;
      r_wait1 <= 1'b0;
      r_wait2 <= 1'b0;
    end else begin
      if (w_in_wait && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      case (r_state)
        EMPTY, FULL: begin
          if (w_accept) begin
            r_rs1_idx <= bus.rs1_idx;
            r_rs2_idx <= bus.rs2_idx;
            if (w_stall1 || w_stall2) begin
              r_state <= WAIT;
              r_op1   <= w_stall1 ? bus.read_data1 : w_data1;
              r_op2   <= w_stall2 ? bus.read_data2 : w_op2_new;
              r_wait1 <= w_stall1;
              r_wait2 <= w_stall2;
            end else begin
              r_state  <= FULL;
              r_input1 <= w_data1;
              r_input2 <= w_op2_new;
            end
          end else if ((r_state == FULL) && bus.out_ready) begin
            r_state <= EMPTY;
          end
        end
        WAIT: begin
          r_op1   <= w_op1_res;
          r_op2   <= w_op2_res;
          r_wait1 <= w_wait1_next;
          r_wait2 <= w_wait2_next;
          if (!w_wait1_next && !w_wait2_next) begin
            r_state  <= FULL;
            r_input1 <= w_op1_res;
            r_input2 <= w_op2_res;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == FULL);
  assign bus.input1    = r_input1;
  assign bus.input2    = r_input2;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a
// randomized run scored against a transaction-level operand model.
module tb_alu_operand_stage;
  import alu_operand_pkg::*;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int IMM_W   = 20;
  localparam int ADDR_W  = 15;
  localparam int BR_W    = 25;
  localparam int NUM_FWD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IMM_W(IMM_W),
    .ADDR_W(ADDR_W), .BR_W(BR_W), .NUM_FWD(NUM_FWD)) bus ();

  alu_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IMM_W(IMM_W),
    .ADDR_W(ADDR_W), .BR_W(BR_W), .NUM_FWD(NUM_FWD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_stall = '0;

  logic              f_valid [NUM_FWD];
  logic              f_pend  [NUM_FWD];
  logic [REG_AW-1:0] f_idx   [NUM_FWD];
  logic [DATA_W-1:0] f_data  [NUM_FWD];

  typedef struct {
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
  } entry_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_fwd();
    for (int k = 0; k < NUM_FWD; k++) begin
      bus.fwd_valid[k]                  = f_valid[k];
      bus.fwd_pend[k]                   = f_pend[k];
      bus.fwd_idx[k*REG_AW +: REG_AW]   = f_idx[k];
      bus.fwd_data[k*DATA_W +: DATA_W]  = f_data[k];
    end
  endtask

  task automatic idle();
    bus.flush = 0; bus.in_valid = 0; bus.src_sel = SRC_REG;
    bus.rs1_idx = '0; bus.rs2_idx = '0; bus.read_data1 = '0; bus.read_data2 = '0;
    bus.immediate = '0; bus.imm_addr = '0; bus.branch_off = '0; bus.out_ready = 0;
    for (int k = 0; k < NUM_FWD; k++) begin
      f_valid[k] = 0; f_pend[k] = 0; f_idx[k] = '0; f_data[k] = '0;
    end
    apply_fwd();
  endtask

  // Two's-complement interpretation of a w-bit field, truncated to 32 bits.
  function automatic logic [DATA_W-1:0] ref_sext(input longint v, input int w);
    if (v >= (longint'(1) << (w - 1))) return DATA_W'(v - (longint'(1) << w));
    return DATA_W'(v);
  endfunction

  // Newest (lowest-index) valid producer of idx wins; register 0 never forwards.
  function automatic logic [DATA_W-1:0] ref_resolve(input logic [REG_AW-1:0] idx,
                                                    input logic [DATA_W-1:0] regd);
    if (idx == 0) return regd;
    for (int k = 0; k < NUM_FWD; k++)
      if (f_valid[k] && f_idx[k] == idx) return f_data[k];
    return regd;
  endfunction

  function automatic logic [DATA_W-1:0] ref_in2();
    case (bus.src_sel)
      SRC_IMM:  return ref_sext(longint'(bus.immediate), IMM_W);
      SRC_ADDR: return ref_sext(longint'(bus.imm_addr), ADDR_W);
      SRC_BR:   return ref_sext(longint'(bus.branch_off), BR_W);
      default:  return ref_resolve(bus.rs2_idx, bus.read_data2);
    endcase
  endfunction

  task automatic test_reset();
    idle();
    bus.in_valid = 1; bus.read_data1 = 32'h1234; bus.read_data2 = 32'h5678;
    rst = 1;
    tick(); tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    n_tests++; if (bus.input1 !== '0) begin n_fail++; $display("FAIL reset_input1 got=%h exp=0", bus.input1); end
    n_tests++; if (bus.input2 !== '0) begin n_fail++; $display("FAIL reset_input2 got=%h exp=0", bus.input2); end
    n_tests++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cnt); end
    rst = 0; bus.in_valid = 0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
  endtask

  task automatic test_imm_sext();
    logic [DATA_W-1:0] e1, e2;
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.in_valid = 1; bus.read_data1 = 32'd5 + DATA_W'(i); bus.read_data2 = 32'hBAD0BAD0;
      case (i)
        0: begin bus.src_sel = SRC_IMM;  bus.immediate  = 20'h80000;   end
        1: begin bus.src_sel = SRC_ADDR; bus.imm_addr   = 15'h4000;    end
        2: begin bus.src_sel = SRC_BR;   bus.branch_off = 25'h1000000; end
        default: begin bus.src_sel = SRC_IMM; bus.immediate = 20'h7FFFF; end
      endcase
      e1 = bus.read_data1;
      e2 = ref_in2();
      if (i == 0) e2 = 32'hFFF80000;
      tick();
      bus.in_valid = 0;
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sext%0d_valid got=%0b exp=1", i, bus.out_valid); end
      n_tests++; if (bus.input1 !== e1) begin n_fail++; $display("FAIL sext%0d_input1 got=%h exp=%h", i, bus.input1, e1); end
      n_tests++; if (bus.input2 !== e2) begin n_fail++; $display("FAIL sext%0d_input2 got=%h exp=%h", i, bus.input2, e2); end
      bus.out_ready = 1; tick(); bus.out_ready = 0;
    end
  endtask

  task automatic test_fwd_priority();
    logic [DATA_W-1:0] e1, e2;
    for (int s = 0; s < 4; s++) begin
      idle();
      bus.in_valid = 1; bus.read_data1 = 32'h1111_0000 + DATA_W'(s); bus.read_data2 = 32'h2222_0000 + DATA_W'(s);
      f_data[0] = 32'hAAAA_AAAA; f_data[1] = 32'hBBBB_BBBB;
      case (s)
        0: begin bus.rs1_idx = 3; f_valid[0] = 1; f_idx[0] = 3; f_valid[1] = 1; f_idx[1] = 3; end
        1: begin bus.rs1_idx = 0; f_valid[0] = 1; f_idx[0] = 0; f_valid[1] = 1; f_idx[1] = 0; end
        2: begin bus.rs1_idx = 7; bus.rs2_idx = 6; f_valid[0] = 1; f_idx[0] = 6; f_valid[1] = 1; f_idx[1] = 7; end
        default: begin bus.rs1_idx = 9; bus.rs2_idx = 9; bus.src_sel = SRC_IMM; bus.immediate = 20'h00123;
                 f_valid[0] = 0; f_idx[0] = 9; f_valid[1] = 1; f_idx[1] = 9; end
      endcase
      apply_fwd();
      e1 = ref_resolve(bus.rs1_idx, bus.read_data1);
      e2 = ref_in2();
      tick();
      bus.in_valid = 0;
      n_tests++; if (bus.input1 !== e1) begin n_fail++; $display("FAIL fwd%0d_input1 got=%h exp=%h", s, bus.input1, e1); end
      n_tests++; if (bus.input2 !== e2) begin n_fail++; $display("FAIL fwd%0d_input2 got=%h exp=%h", s, bus.input2, e2); end
      bus.out_ready = 1; tick(); bus.out_ready = 0;
    end
  endtask

  task automatic test_load_use();
    idle();
    bus.in_valid = 1; bus.src_sel = SRC_REG; bus.rs1_idx = 0; bus.read_data1 = 32'h11;
    bus.rs2_idx = 4; bus.read_data2 = 32'h2222;
    f_valid[0] = 1; f_idx[0] = 4; f_pend[0] = 1; f_data[0] = 32'hDEAD;
    apply_fwd();
    tick();
    bus.in_valid = 0;
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_wait%0d_valid got=%0b exp=0", c, bus.out_valid); end
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_wait%0d_in_ready got=%0b exp=0", c, bus.in_ready); end
      if (c == 2) begin f_pend[0] = 0; f_data[0] = 32'd77; apply_fwd(); end
      tick();
    end
    exp_stall = exp_stall + 16'd3;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL lu_valid got=%0b exp=1", bus.out_valid); end
    n_tests++; if (bus.input1 !== 32'h11) begin n_fail++; $display("FAIL lu_input1 got=%h exp=11", bus.input1); end
    n_tests++; if (bus.input2 !== 32'd77) begin n_fail++; $display("FAIL lu_input2 got=%0d exp=77", bus.input2); end
    n_tests++; if (bus.stall_cnt !== exp_stall) begin n_fail++; $display("FAIL lu_stall got=%0d exp=%0d", bus.stall_cnt, exp_stall); end
    idle(); bus.out_ready = 1; tick(); bus.out_ready = 0;
    // Producer retires while waiting: the captured register value is kept.
    bus.in_valid = 1; bus.src_sel = SRC_IMM; bus.immediate = 20'd1;
    bus.rs1_idx = 5; bus.read_data1 = 32'h1234;
    f_valid[0] = 1; f_idx[0] = 5; f_pend[0] = 1; f_data[0] = 32'hDEAD;
    apply_fwd();
    tick();
    bus.in_valid = 0; f_valid[0] = 0; apply_fwd();
    tick();
    exp_stall = exp_stall + 16'd1;
    n_tests++; if (bus.input1 !== 32'h1234) begin n_fail++; $display("FAIL retire_input1 got=%h exp=1234", bus.input1); end
    n_tests++; if (bus.input2 !== 32'd1) begin n_fail++; $display("FAIL retire_input2 got=%h exp=1", bus.input2); end
    n_tests++; if (bus.stall_cnt !== exp_stall) begin n_fail++; $display("FAIL retire_stall got=%0d exp=%0d", bus.stall_cnt, exp_stall); end
    bus.out_ready = 1; tick(); bus.out_ready = 0;
  endtask

  task automatic test_back_to_back();
    idle();
    bus.in_valid = 1; bus.read_data1 = 32'hA1; bus.read_data2 = 32'hA2;
    tick();
    bus.read_data1 = 32'hB1; bus.read_data2 = 32'hB2;
    for (int c = 0; c < 5; c++) begin
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_valid got=%0b exp=1", c, bus.out_valid); end
      n_tests++; if (bus.input1 !== 32'hA1 || bus.input2 !== 32'hA2) begin n_fail++; $display("FAIL bp%0d_hold got=%h/%h exp=a1/a2", c, bus.input1, bus.input2); end
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_in_ready got=%0b exp=0", c, bus.in_ready); end
      tick();
    end
    bus.out_ready = 1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got=%0b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 0;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got=%0b exp=1", bus.out_valid); end
    n_tests++; if (bus.input1 !== 32'hB1 || bus.input2 !== 32'hB2) begin n_fail++; $display("FAIL b2b_data got=%h/%h exp=b1/b2", bus.input1, bus.input2); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%0b exp=0", bus.out_valid); end
    n_tests++; if (bus.input1 !== 32'hB1 || bus.input2 !== 32'hB2) begin n_fail++; $display("FAIL drain_hold got=%h/%h exp=b1/b2", bus.input1, bus.input2); end
    bus.out_ready = 0;
  endtask

  task automatic test_flush();
    idle();
    bus.in_valid = 1; bus.rs1_idx = 2; bus.read_data1 = 32'h99;
    f_valid[0] = 1; f_idx[0] = 2; f_pend[0] = 1;
    apply_fwd();
    tick();
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_in_ready got=%0b exp=0", bus.in_ready); end
    bus.flush = 1;
    tick();
    bus.flush = 0; bus.in_valid = 0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%0b exp=0", bus.out_valid); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%0b exp=1", bus.in_ready); end
    n_tests++; if (bus.stall_cnt !== exp_stall) begin n_fail++; $display("FAIL flush_stall got=%0d exp=%0d", bus.stall_cnt, exp_stall); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stay_valid got=%0b exp=0", bus.out_valid); end
    // Flush in FULL with a simultaneous accept discards the new entry.
    idle(); bus.in_valid = 1; bus.read_data1 = 32'h55;
    tick();
    bus.out_ready = 1; bus.flush = 1; bus.read_data1 = 32'h66;
    tick();
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 0;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full_valid got=%0b exp=0", bus.out_valid); end
  endtask

  task automatic test_random();
    entry_t q[$];
    entry_t e;
    logic   exp_ready, acc;
    idle();
    for (int it = 0; it < 400; it++) begin
      n_tests++;
      if (bus.out_valid !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rnd%0d_valid got=%0b exp=%0b", it, bus.out_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        n_tests++;
        if (bus.input1 !== q[0].in1 || bus.input2 !== q[0].in2) begin
          n_fail++; $display("FAIL rnd%0d_data got=%h/%h exp=%h/%h", it, bus.input1, bus.input2, q[0].in1, q[0].in2);
        end
      end
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      bus.src_sel    = src_sel_e'($urandom_range(0, 3));
      bus.rs1_idx    = REG_AW'($urandom_range(0, 7));
      bus.rs2_idx    = REG_AW'($urandom_range(0, 7));
      bus.read_data1 = $urandom; bus.read_data2 = $urandom;
      bus.immediate  = IMM_W'($urandom); bus.imm_addr = ADDR_W'($urandom);
      bus.branch_off = BR_W'($urandom);
      for (int k = 0; k < NUM_FWD; k++) begin
        f_valid[k] = $urandom_range(0, 1) != 0; f_pend[k] = 0;
        f_idx[k] = REG_AW'($urandom_range(0, 7)); f_data[k] = $urandom;
      end
      apply_fwd();
      #1;
      exp_ready = (q.size() == 0) || bus.out_ready;
      n_tests++;
      if (bus.in_ready !== exp_ready) begin
        n_fail++; $display("FAIL rnd%0d_in_ready got=%0b exp=%0b", it, bus.in_ready, exp_ready);
      end
      acc   = bus.in_valid && exp_ready;
      e.in1 = ref_resolve(bus.rs1_idx, bus.read_data1);
      e.in2 = ref_in2();
      @(posedge clk);
      if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
      if (acc) q.push_back(e);
      #1;
    end
    idle(); bus.out_ready = 1; tick(); bus.out_ready = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_imm_sext();
    test_fwd_priority();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
